// File: rtl/bp_pkg.sv
// Shared types and constants for the 2-bit saturating-counter branch predictor.
package bp_pkg;

  typedef logic [1:0] counter_t;

  localparam counter_t SNT = 2'b00;
  localparam counter_t WNT = 2'b01;
  localparam counter_t WT  = 2'b10;
  localparam counter_t ST  = 2'b11;

endpackage

// File: rtl/sat_counter_update.sv
// Next-state function of one 2-bit saturating counter: count up on taken,
// down on not-taken, holding at the ends.
module sat_counter_update
  import bp_pkg::*;
(
  input  counter_t state,
  input  logic     taken,
  output counter_t next_state
);

  always_comb begin
    // NOTE: default first so every path assigns next_state; no latch is inferred.
    next_state = state;
    if (taken) begin
      if (state != ST) next_state = state + 2'd1;
    end else begin
      if (state != SNT) next_state = state - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: a PC-indexed table of 2-bit counters read in decode
// and trained at MEM resolution through a fixed-depth index delay line.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int       INDEX_BITS  = 6,
  parameter int       UPDATE_LAT  = 2,
  parameter counter_t RESET_STATE = WNT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        actual_branch_decision,
  input  logic        branch_decode_sig,
  input  logic        branch_mem_sig,
  input  logic [31:0] in_addr,
  input  logic [31:0] offset,
  output logic [31:0] branch_addr,
  output logic        prediction
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  typedef logic [INDEX_BITS-1:0] idx_t;

  counter_t table_q [ENTRIES];
  idx_t     rd_idx;
  idx_t     upd_idx;
  counter_t upd_next;

  // Word-aligned PC: the byte-offset bits and the bits above the index never select an entry.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{in_addr[31:INDEX_BITS+2], in_addr[1:0]};

  assign rd_idx      = in_addr[INDEX_BITS+1:2];
  assign branch_addr = in_addr + offset;
  assign prediction  = branch_decode_sig & table_q[rd_idx][1];

  generate
    if (UPDATE_LAT == 0) begin : g_no_delay
      assign upd_idx = rd_idx;
    end else begin : g_delay
      idx_t dly_q [UPDATE_LAT];

      // Carries each decode index forward so it meets its own outcome in MEM.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < UPDATE_LAT; i++) dly_q[i] <= '0;
        end else begin
          // NOTE: non-blocking assignments make every stage shift from its pre-edge value.
          dly_q[0] <= rd_idx;
          for (int i = 1; i < UPDATE_LAT; i++) dly_q[i] <= dly_q[i-1];
        end
      end

      assign upd_idx = dly_q[UPDATE_LAT-1];
    end
  endgenerate

  sat_counter_update u_sat (
    .state      (table_q[upd_idx]),
    .taken      (actual_branch_decision),
    .next_state (upd_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the table is register-based, so it can and must be reset to a known bias.
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= RESET_STATE;
    end else if (branch_mem_sig) begin
      table_q[upd_idx] <= upd_next;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench: directed steps then randomized traffic against a
// behavioural model of the counter table and the decode-to-MEM index latency.
module tb_branch_predictor;

  localparam int IB  = 6;
  localparam int LAT = 2;
  localparam int N   = 1 << IB;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        abd;
  logic        dec;
  logic        mem;
  logic [31:0] in_addr;
  logic [31:0] offset;
  logic [31:0] branch_addr;
  logic        prediction;

  int checks = 0;
  int errors = 0;

  // Model: counter strength as an integer 0..3 per entry, and the decode
  // indices still in flight toward MEM (front = the one resolving next).
  int ctr [N];
  int inflight [$];

  always #5 clk = ~clk;

  branch_predictor #(
    .INDEX_BITS  (IB),
    .UPDATE_LAT  (LAT),
    .RESET_STATE (2'b01)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .actual_branch_decision (abd),
    .branch_decode_sig      (dec),
    .branch_mem_sig         (mem),
    .in_addr                (in_addr),
    .offset                 (offset),
    .branch_addr            (branch_addr),
    .prediction             (prediction)
  );

  function automatic int idx_of(logic [31:0] a);
    return int'((a >> 2) % N);
  endfunction

  task automatic model_reset();
    foreach (ctr[i]) ctr[i] = 1;
    inflight.delete();
    for (int i = 0; i < LAT; i++) inflight.push_back(0);
  endtask

  task automatic model_edge();
    int u;
    if (!rst_n) begin
      model_reset();
      return;
    end
    u = (LAT == 0) ? idx_of(in_addr) : inflight[0];
    if (mem) begin
      if (abd) ctr[u] = (ctr[u] >= 3) ? 3 : ctr[u] + 1;
      else     ctr[u] = (ctr[u] <= 0) ? 0 : ctr[u] - 1;
    end
    if (LAT > 0) begin
      inflight.push_back(idx_of(in_addr));
      void'(inflight.pop_front());
    end
  endtask

  function automatic logic model_pred();
    return dec && (ctr[idx_of(in_addr)] >= 2);
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model(string tag);
    logic [31:0] exp_addr;
    exp_addr = in_addr + offset;
    check({tag, "_pred"}, {31'd0, prediction}, {31'd0, model_pred()});
    check({tag, "_addr"}, branch_addr, exp_addr);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    model_reset();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stim
    logic exp_seq [9];
    logic dir_seq [9];
    dir_seq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    // Reset values while reset is held.
    rst_n = 1'b0; dec = 1'b1; mem = 1'b0; abd = 1'b0;
    in_addr = 32'h84; offset = 32'h0;
    model_reset();
    #2;
    check("reset_pred", {31'd0, prediction}, 32'd0);
    check("reset_addr", branch_addr, 32'h84);
    tick();

    // Release reset, let the delay line fill, then train the 0x84 entry.
    rst_n = 1'b1; mem = 1'b1; abd = 1'b0;
    repeat (LAT) tick();
    for (int i = 0; i < 9; i++) begin
      abd = dir_seq[i];
      tick();
      check($sformatf("seq%0d", i), {31'd0, prediction}, {31'd0, exp_seq[i]});
    end

    // Saturation at the bottom: four not-taken from reset, then one taken.
    reset_pulse();
    mem = 1'b0;
    repeat (LAT) tick();
    mem = 1'b1; abd = 1'b0;
    repeat (4) tick();
    check("underflow_pred", {31'd0, prediction}, 32'd0);
    abd = 1'b1;
    tick();
    check("after_one_taken", {31'd0, prediction}, 32'd0);
    tick();
    check("after_two_taken", {31'd0, prediction}, 32'd1);
    tick();

    // Strongly taken at 0x84; a neighbouring index is untouched.
    mem = 1'b0;
    in_addr = 32'h88; #1;
    check("other_index", {31'd0, prediction}, 32'd0);
    in_addr = 32'h84; #1;
    check("trained_index", {31'd0, prediction}, 32'd1);

    // Decode gating, then weakly-taken entry must survive ignored outcomes.
    dec = 1'b0; #1;
    check("decode_gate", {31'd0, prediction}, 32'd0);
    dec = 1'b1; mem = 1'b1; abd = 1'b0;
    tick();
    mem = 1'b0;
    for (int i = 0; i < 6; i++) begin
      abd = (i == 5) ? 1'bx : ~abd;
      tick();
      check($sformatf("mem_gate%0d", i), {31'd0, prediction}, 32'd1);
    end

    // Target address wrap-around.
    abd = 1'b0;
    in_addr = 32'hFFFF_FFFC; offset = 32'h8; #1;
    check("addr_wrap", branch_addr, 32'h0000_0004);

    // Train to strongly taken, then reset between edges clears it at once.
    in_addr = 32'h84; offset = 32'h0; mem = 1'b1; abd = 1'b1;
    repeat (4) tick();
    check("pre_async_reset", {31'd0, prediction}, 32'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_reset", {31'd0, prediction}, 32'd0);
    tick();
    rst_n = 1'b1;

    // Randomized traffic over a few colliding indices.
    for (int i = 0; i < 400; i++) begin
      in_addr = $urandom;
      in_addr[IB+1:2] = IB'($urandom_range(0, 3));
      offset = $urandom;
      dec = 1'($urandom);
      mem = 1'($urandom_range(0, 3) != 0);
      abd = 1'($urandom);
      #1;
      check_model($sformatf("rnd%0d", i));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
